dmem_responder: RTL and testbench

- Handshaked data-memory responder: the target end of the core's load/store request interface.
- Accepts one request at a time and models a fixed access latency.
- Performs RV32 byte/half/word stores and sign/zero-extending loads selected by funct3.
- Returns a response with read data and an error flag. Sits behind the memory stage at the data region (base 0x02000000).

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed access latency,
// RV32 byte/half/word stores and sign/zero-extending loads selected by funct3.
module dmem_responder #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 'h0200_0000,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic              req_wren_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  logic [AWIDTH-1:0] offset;
  logic [IW-1:0]     word_idx;
  logic [1:0]        lane;
  logic              illegal, misaligned, out_of_range, err, accept;
  logic [3:0]        be;
  logic [DWIDTH-1:0] wdata_lanes;
  logic [DWIDTH-1:0] rdata_p0;
  logic              err_p0;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ln,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {ln, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'b00:   return 4'b0001 << ln;
      2'b01:   return 4'b0011 << ln;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign offset       = req_addr_i - BASE_ADDR;
  assign word_idx     = offset[IW+1:2];
  assign lane         = offset[1:0];
  assign out_of_range = offset >= AWIDTH'(4 * DEPTH_WORDS);
  assign err          = illegal | misaligned | out_of_range;
  assign accept       = (state == S_IDLE) && req_valid_i;
  assign be           = byte_en(req_funct3_i[1:0], lane);
  assign wdata_lanes  = replicate(req_funct3_i[1:0], req_wdata_i);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_wren_i) illegal = (req_funct3_i > 3'd2);
    else            illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (req_funct3_i[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = (offset[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Accept edge: commit good stores, capture the response payload
  always_ff @(posedge clk) begin
    if (accept && req_wren_i && !err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
    end
    if (accept) begin
      err_p0   <= err;
      rdata_p0 <= (req_wren_i || err) ? '0 : load_ext(req_funct3_i, lane, mem[word_idx]);
    end
  end

  always_comb begin
    state_n     = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_n = S_WAIT;
      end
      S_WAIT: if (cnt == CW'(LATENCY - 1)) state_n = S_RESP;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control state and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept)                            cnt <= '0;
      else if (state == S_WAIT && cnt != '1) cnt <= cnt + 1'b1;
      if (state == S_WAIT && state_n == S_RESP) begin
        rsp_rdata_o <= rdata_p0;
        rsp_err_o   <= err_p0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-addressed
// reference memory model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          LAT  = 2;
  localparam int          NBYTES = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wren = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mm [NBYTES];

  always #5 clk = ~clk;

  dmem_responder #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wren_i(req_wren), .req_funct3_i(req_funct3), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory plus the RV32 access rules
  task automatic model(input logic [31:0] a, input logic w, input logic [2:0] f3,
                       input logic [31:0] d, output logic [31:0] er, output logic ee);
    int unsigned off;
    int size;
    logic illegal;
    off  = a - BASE;
    size = 1 << f3[1:0];
    illegal = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ee = illegal || (off % size != 0) || (off >= NBYTES);
    er = '0;
    if (!ee && w) begin
      for (int i = 0; i < size; i++) mm[off + i] = d[8*i +: 8];
    end else if (!ee) begin
      for (int i = 0; i < size; i++) er[8*i +: 8] = mm[off + i];
      if (!f3[2] && size < 4 && er[8*size - 1]) er = er | ~((32'h1 << (8*size)) - 1);
    end
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic [2:0] f3,
                      input logic [31:0] d, input int hold, input string tag);
    logic [31:0] er;
    logic ee;
    int cyc;
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_wren = w; req_funct3 = f3; req_wdata = d;
    rsp_ready = 1'b0;
    model(a, w, f3, d, er, ee);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(LAT));
    chk({tag, ".rdata"}, rsp_rdata, er);
    chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, ee});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.hold%0d.valid", tag, k), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("%s.hold%0d.rdata", tag, k), rsp_rdata, er);
      chk($sformatf("%s.hold%0d.err", tag, k), {31'b0, rsp_err}, {31'b0, ee});
      chk($sformatf("%s.hold%0d.ready", tag, k), {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ".idle_valid"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic w;
    logic [2:0] f3;
    int r;

    #1;
    chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_err", {31'b0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) xact(BASE + 32'(4*i), 1'b1, 3'b010, $urandom, 0, "init");

    xact(BASE,                1'b1, 3'b010, 32'hDEAD_BEEF, 0, "sw_base");
    xact(BASE,                1'b0, 3'b010, 32'h0,         0, "lw_base");
    xact(BASE + 32'h5,        1'b1, 3'b000, 32'h0000_0080, 0, "sb_5");
    xact(BASE + 32'h5,        1'b0, 3'b000, 32'h0,         0, "lb_5");
    xact(BASE + 32'h5,        1'b0, 3'b100, 32'h0,         0, "lbu_5");
    xact(BASE + 32'h4,        1'b0, 3'b010, 32'h0,         0, "lw_4");
    xact(BASE + 32'h2,        1'b1, 3'b001, 32'h0000_1234, 0, "sh_2");
    xact(BASE + 32'h2,        1'b0, 3'b101, 32'h0,         0, "lhu_2");
    xact(BASE + 32'h2,        1'b0, 3'b010, 32'h0,         0, "lw_mis");
    xact(BASE + 32'h1,        1'b1, 3'b010, 32'hFFFF_FFFF, 0, "sw_mis");
    xact(BASE,                1'b0, 3'b010, 32'h0,         0, "lw_after_mis");
    xact(BASE + 32'h1000,     1'b0, 3'b010, 32'h0,         0, "lw_oor");
    xact(BASE + 32'h8,        1'b1, 3'b011, 32'h5555_5555, 0, "s_f3_011");
    xact(BASE + 32'h8,        1'b0, 3'b010, 32'h0,         0, "lw_after_bad");
    xact(BASE + 32'h4,        1'b0, 3'b010, 32'h0,         3, "backpressure");

    // Asynchronous reset while a load is waiting
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE; req_wren = 1'b0; req_funct3 = 3'b010;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst.req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    xact(BASE, 1'b0, 3'b010, 32'h0, 0, "after_rst");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) a = BASE - 32'd4;
      else             a = BASE + 32'($urandom_range(0, 63));
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      d  = $urandom;
      xact(a, w, f3, d, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
